// File: rtl/median_window.sv
// 3x3 window serialiser feeding the median stage: two line buffers, a sliding
// window register, and a 9-cycle DO/DSO burst per interior pixel.
module median_window #(
    parameter int W      = 8,
    parameter int LINE_W = 16
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic [W-1:0] PIX_IN,
    input  logic         PIX_VALID,
    input  logic         SOF,
    output logic         PIX_READY,
    output logic [W-1:0] DO,
    output logic         DSO,
    input  logic         MED_DONE
);
    localparam int CW = $clog2(LINE_W);

    typedef enum logic [1:0] {IDLE, EMIT, WAIT} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] col, acol;
    logic [1:0]    row, arow;
    logic [3:0]    k;
    logic [W-1:0]  w   [9];
    logic [W-1:0]  lb0 [LINE_W];
    logic [W-1:0]  lb1 [LINE_W];
    logic [W-1:0]  top, mid;
    logic          acc, win;

    // SOF forces the accepted pixel to (0,0) regardless of the running counters
    always_comb begin
        acc  = PIX_VALID && PIX_READY;
        acol = SOF ? '0 : col;
        arow = SOF ? '0 : row;
        top  = lb1[acol];
        mid  = lb0[acol];
        win  = arow[1] && (acol >= CW'(2));
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (acc && win) state_nx = EMIT;
            EMIT:    if (k == 4'd8) state_nx = WAIT;
            WAIT:    if (MED_DONE) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        PIX_READY = (state == IDLE);
        DSO       = (state == EMIT);
        DO        = (state == EMIT) ? w[k] : w[8];
    end

    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            state <= IDLE;
            k     <= '0;
        end else begin
            state <= state_nx;
            if (state == EMIT && k != 4'd8) k <= k + 4'd1;
            else                             k <= '0;
        end
    end

    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            col <= '0;
            row <= '0;
            for (int unsigned i = 0; i < 9; i++) w[i] <= '0;
        end else if (acc) begin
            if (acol == CW'(LINE_W - 1)) begin
                col <= '0;
                row <= arow[1] ? 2'd2 : arow + 2'd1;
            end else begin
                col <= acol + CW'(1);
                row <= arow;
            end
            for (int unsigned i = 0; i < 3; i++) begin
                w[3*i]   <= w[3*i+1];
                w[3*i+1] <= w[3*i+2];
            end
            w[2] <= top;
            w[5] <= mid;
            w[8] <= PIX_IN;
        end
    end

    // Line buffers are deliberately unreset; row gating masks stale data
    always_ff @(posedge CLK) begin
        if (acc) begin
            lb1[acol] <= mid;
            lb0[acol] <= PIX_IN;
        end
    end

endmodule

// File: tb/tb_median_window.sv
// Directed bench for median_window with LINE_W=4 and pixel value row*16+col (+base).
module tb_median_window;
    localparam int W  = 8;
    localparam int LW = 4;

    logic         CLK = 1'b0;
    logic         nRST;
    logic [W-1:0] PIX_IN;
    logic         PIX_VALID;
    logic         SOF;
    logic         PIX_READY;
    logic [W-1:0] DO;
    logic         DSO;
    logic         MED_DONE;

    int vectors     = 0;
    int miscompares = 0;
    int win_cnt     = 0;
    int dso_cycles  = 0;

    logic [W-1:0] cap       [9];
    logic [W-1:0] first_win [9];
    logic [W-1:0] fourth_win[9];
    logic [W-1:0] exp1      [9];
    logic [W-1:0] exp4      [9];

    always #5 CLK = ~CLK;

    median_window #(.W(W), .LINE_W(LW)) dut (
        .CLK(CLK), .nRST(nRST), .PIX_IN(PIX_IN), .PIX_VALID(PIX_VALID), .SOF(SOF),
        .PIX_READY(PIX_READY), .DO(DO), .DSO(DSO), .MED_DONE(MED_DONE)
    );

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_p(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic send_pixel(input logic [W-1:0] v, input logic sof);
        int n;
        n = 0;
        PIX_IN = v; SOF = sof; PIX_VALID = 1'b1;
        while (PIX_READY !== 1'b1 && n < 50) begin
            tick;
            n++;
        end
        if (n >= 50) begin
            miscompares++;
            $error("FAIL accept_timeout observed=ready_low expected=ready_high");
        end
        tick;
        PIX_VALID = 1'b0; SOF = 1'b0;
    endtask

    // Samples the 9-cycle burst; pulses MED_DONE during EMIT at index pulse_at
    task automatic get_window(input int pulse_at);
        for (int i = 0; i < 9; i++) begin
            chk_b("dso_high", DSO, 1'b1);
            chk_b("ready_low_emit", PIX_READY, 1'b0);
            cap[i] = DO;
            if (DSO === 1'b1) dso_cycles++;
            MED_DONE = (i == pulse_at);
            tick;
        end
        MED_DONE = 1'b0;
        chk_b("dso_low_after", DSO, 1'b0);
        chk_b("ready_low_wait", PIX_READY, 1'b0);
    endtask

    task automatic check_cap(input int base, input int r, input int c);
        for (int i = 0; i < 9; i++)
            chk_p("win_px", cap[i], W'(base + (r - 2 + i / 3) * 16 + (c - 2 + i % 3)));
    endtask

    task automatic med_done(input int d);
        for (int i = 0; i < d; i++) begin
            chk_b("ready_low_pre_done", PIX_READY, 1'b0);
            tick;
        end
        MED_DONE = 1'b1;
        tick;
        MED_DONE = 1'b0;
        chk_b("ready_after_done", PIX_READY, 1'b1);
    endtask

    task automatic feed(input int base, input int first, input int last);
        int r, c;
        for (int i = first; i <= last; i++) begin
            r = i / LW;
            c = i % LW;
            send_pixel(W'(base + r * 16 + c), (i == 0));
            if (r >= 2 && c >= 2) begin
                get_window(-1);
                check_cap(base, r, c);
                win_cnt++;
                if (win_cnt == 1) first_win = cap;
                if (win_cnt == 4) fourth_win = cap;
                med_done(3);
            end else begin
                chk_b("no_window", DSO, 1'b0);
                chk_b("ready_next", PIX_READY, 1'b1);
            end
        end
    endtask

    initial begin
        exp1 = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22};
        exp4 = '{8'h11, 8'h12, 8'h13, 8'h21, 8'h22, 8'h23, 8'h31, 8'h32, 8'h33};
        nRST = 1'b1; PIX_IN = '0; PIX_VALID = 1'b0; SOF = 1'b0; MED_DONE = 1'b0;
        #1;
        chk_b("reset_dso", DSO, 1'b0);
        chk_p("reset_do", DO, '0);
        chk_b("reset_ready", PIX_READY, 1'b1);
        PIX_VALID = 1'b1; SOF = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk_b("reset_hold_dso", DSO, 1'b0);
        end
        nRST = 1'b0; PIX_VALID = 1'b0; SOF = 1'b0;
        tick;

        // Full 4x4 frame: four windows, 36 strobe cycles
        win_cnt = 0; dso_cycles = 0;
        feed(0, 0, 15);
        chk_i("window_count", win_cnt, 4);
        chk_i("dso_cycles", dso_cycles, 36);
        for (int i = 0; i < 9; i++) chk_p("first_window", first_win[i], exp1[i]);
        for (int i = 0; i < 9; i++) chk_p("fourth_window", fourth_win[i], exp4[i]);

        // Handshake: MED_DONE in EMIT ignored, held pixel waits through WAIT
        feed(0, 0, 9);
        send_pixel(8'h22, 1'b0);
        get_window(3);
        check_cap(0, 2, 2);
        PIX_IN = 8'h23; PIX_VALID = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk_b("wait_ready_low", PIX_READY, 1'b0);
            chk_b("wait_dso_low", DSO, 1'b0);
            tick;
        end
        MED_DONE = 1'b1;
        tick;
        MED_DONE = 1'b0;
        chk_b("ready_after_wait_done", PIX_READY, 1'b1);
        tick;
        PIX_VALID = 1'b0;
        get_window(-1);
        check_cap(0, 2, 3);
        med_done(3);
        feed(0, 12, 15);

        // SOF restart at (3,1): new frame windows hold only new pixels
        feed(0, 0, 12);
        feed(8'h80, 0, 10);

        // Reset while emitting at k=4
        feed(0, 0, 9);
        send_pixel(8'h22, 1'b0);
        for (int i = 0; i < 4; i++) tick;
        chk_b("emit_k4_dso", DSO, 1'b1);
        chk_p("emit_k4_do", DO, 8'h11);
        nRST = 1'b1;
        #1;
        chk_b("midwin_reset_dso", DSO, 1'b0);
        chk_p("midwin_reset_do", DO, '0);
        chk_b("midwin_reset_ready", PIX_READY, 1'b1);
        PIX_VALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk_b("midwin_hold_dso", DSO, 1'b0);
        end
        nRST = 1'b0; PIX_VALID = 1'b0;
        tick;
        win_cnt = 0;
        feed(0, 0, 15);
        chk_i("post_reset_windows", win_cnt, 4);
        for (int i = 0; i < 9; i++) chk_p("post_reset_first", first_win[i], exp1[i]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/median_window.md
Name: median_window

Overview:
- Upstream feeder for the 3x3 median stage.
- Takes a raster pixel stream with a valid/ready handshake and keeps the two previous lines in line buffers.
- For every pixel that completes a full 3x3 neighbourhood, serialises the 9 window pixels onto DO with DSO high for 9 consecutive cycles. This matches the median stage's DI/DSI input.
- Then stalls the stream until the median stage reports completion on MED_DONE.

Parameters:
- W, 8: pixel width in bits.
- LINE_W, 16: pixels per line (≥3). Column counter width is $clog2(LINE_W).

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- nRST  in  1  reset, asynchronous, active-high.
- PIX_IN  in  W  input pixel, raster order.
- PIX_VALID  in  1  PIX_IN valid.
- SOF  in  1  qualifies PIX_IN as pixel (0,0) of a new frame; sampled only on an accepted pixel.
- PIX_READY  out  1  block can accept a pixel this cycle.
- DO  out  W  serialised window pixel, to the median DI.
- DSO  out  1  window strobe, to the median DSI; high for exactly 9 consecutive cycles per window.
- MED_DONE  in  1  single-cycle pulse from the median DSO.

Behaviour:
- Reset (nRST=1, async):
  - state=IDLE, col=0, row=0, k=0.
  - Window registers w[0..8]=0.
  - DSO=0, DO=0, PIX_READY=1, all immediately.
  - Line buffer RAM is not cleared; row gating makes stale contents don't-care.
- Storage:
  - lb0[LINE_W] holds line r-1, lb1[LINE_W] holds line r-2, each W bits.
  - 3x3 window register w[0..8], row-major: w[0]=(r-2,c-2) … w[8]=(r,c).
- Accept:
  - A pixel is accepted when PIX_VALID && PIX_READY at a rising edge.
  - If SOF=1 on the accepted pixel, it is treated as col=0, row=0, regardless of the counters.
- On accept at (row, col):
  - top=lb1[col], mid=lb0[col].
  - Write lb1[col]<=mid and lb0[col]<=PIX_IN.
  - Shift the window left one column, discarding the oldest column.
  - New right column is w[2]=top, w[5]=mid, w[8]=PIX_IN.
  - Column advance: col==LINE_W-1 → col=0 and row=min(row+1,2); else col+1.
  - Row saturates at 2; only row≥2 matters.
- FSM:
  - IDLE: PIX_READY=1, DSO=0. On accept, if row≥2 && col≥2 (pre-increment coordinates) → EMIT with k=0; otherwise stay in IDLE.
  - EMIT: PIX_READY=0, DSO=1, DO=w[k]. k increments each cycle; at k==8 → WAIT and k=0.
  - WAIT: PIX_READY=0, DSO=0. On MED_DONE=1 → IDLE, with PIX_READY=1 the following cycle.
- MED_DONE in IDLE or EMIT is ignored and is not remembered.
- Outputs:
  - DO and DSO are decoded from registers only; there is no combinational path from any input.
  - When not in EMIT, DO=w[8].
- Latency: pixel accepted at edge t → DSO=1 with DO=w[0] in the cycle after t, through the cycle after t+8.
- Throughput: at most one window per 9 + (median latency) cycles. Non-emitting pixels are accepted back-to-back, one per cycle.
- Output image size: (rows−2)×(LINE_W−2) windows. Border pixels produce no window.
- Backpressure: PIX_VALID held while PIX_READY=0 has no effect, and no pixel is lost.
- SOF mid-frame: counters restart as above and the window shift proceeds normally. No window is emitted until row 2, col 2 of the new frame.
- Reset mid-EMIT or mid-WAIT:
  - DSO drops asynchronously.
  - The in-flight window is abandoned.
  - The next frame must start with SOF.

Test Plan:
- Reset: assert nRST mid-stream → DSO=0, DO=0, PIX_READY=1 the same cycle; hold 3 cycles with PIX_VALID=1 → no window emitted.
- First window: LINE_W=4, pixel value = row*16+col, SOF on (0,0), PIX_VALID always 1, MED_DONE pulsed 3 cycles after DSO falls → after pixel (2,2), DSO high 9 cycles with DO = 0x00,0x01,0x02,0x10,0x11,0x12,0x20,0x21,0x22.
- Window count: feed a 4x4 frame (LINE_W=4) → exactly 4 windows (36 DSO-high cycles). The fourth window is 0x11,0x12,0x13,0x21,0x22,0x23,0x31,0x32,0x33.
- Handshake: hold MED_DONE=0 for 20 cycles after a window → PIX_READY stays 0 and the pixel held on PIX_IN is not consumed. A MED_DONE pulse during EMIT is ignored; one in WAIT gives PIX_READY=1 the next cycle.
- SOF restart: assert SOF at (3,1) of the first frame → no DSO until new (2,2). The first new window contains only new-frame pixels.
- Reset mid-window: assert nRST at EMIT k=4 → DSO=0 immediately. A subsequent full 4x4 frame reproduces the window values from the first-window scenario.
